kmer_isect_engine: RTL and testbench
====================================

# kmer_isect_engine

Parametrised sorted-stream intersection engine for the bucket-matching stage: merges a DRAM-side sorted key stream (A) against a flash-side sorted key/ID stream (B) over a configurable number of passes. In mode 0 it emits A∩B matches; in mode 1 it emits A-only keys. It owns the compare datapath and all valid/ready handshakes. It also drives per-pass offset advance and completion strobes for the surrounding bucket controller.

## Interface
- KEY_W, 64, key width in bits
- ID_W, 32, payload ID width carried on stream B
- NUM_STEPS, 3, passes per bucket (≥1)
- CNT_W, 32, match counter width
- STEP_W, $clog2(NUM_STEPS) (min 1), derived, not overridable
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  bucket arrived; sampled only in IDLE
- mode  in  1  0 = intersect, 1 = A-minus-B; latched on accepted start
- busy  out  1  high from PREP through DONE
- done  out  1  one-cycle pulse in DONE
- a_valid / a_ready  in / out  1  stream A handshake
- a_key  in  KEY_W  A key, ascending within a pass
- a_last  in  1  final A beat of current pass
- b_valid / b_ready  in / out  1  stream B handshake
- b_key  in  KEY_W  B key, ascending within a pass
- b_id  in  ID_W  B payload
- b_last  in  1  final B beat of current pass
- m_valid / m_ready  out / in  1  result handshake
- m_key  out  KEY_W  result key
- m_id  out  ID_W  b_id on match, 0 in mode 1
- step_idx  out  STEP_W  current pass
- step_adv  out  1  one-cycle pulse at end of every pass
- match_cnt  out  CNT_W  results emitted since start, wrapping

## Operation
- Two head registers (key, id, last, hv). Beat accepted on valid&ready → hv=1. Pop clears hv; popping a head with last=1 sets that stream's exhausted flag (ex_a/ex_b).
- IDLE: all readies 0. start → PREP.
- PREP (1 cycle): clear heads, ex flags, match_cnt; step_idx=0; latch mode → FILL.
- FILL: a_ready = !a_hv & !ex_a; b_ready likewise.
  - Exit rule 1: mode 0 with ex_a|ex_b, or mode 1 with ex_a → DRAIN.
  - Exit rule 2: mode 1, ex_b, a_hv → EMIT of A head (pop A on handshake).
  - Exit rule 3: a_hv & b_hv → CMP.
- CMP (1 cycle), unsigned compare:
  - A==B: mode 0 → EMIT {a_key, b_id}, pop both on handshake; mode 1 → pop both → FILL.
  - A<B: mode 0 pop A → FILL; mode 1 → EMIT {a_key, 0}, pop A on handshake.
  - A>B: pop B → FILL.
- EMIT: m_valid=1, m_key/m_id stable until m_ready. On handshake: pop, match_cnt+1 → FILL.
- DRAIN: accept and discard beats of the unexhausted stream(s) until its last beat; both ex set → STEP_END.
- STEP_END (1 cycle): step_adv=1.
  - If step_idx==NUM_STEPS-1 → DONE.
  - Otherwise: step_idx+1, clear heads and ex flags → FILL.
- DONE (1 cycle): done=1 → IDLE.
- Duplicate keys: one result per equal pair; surplus duplicates are popped by the </> rules.

## Timing
- Reset values: all readies, m_valid, busy, done, step_adv = 0; m_key, m_id, step_idx, match_cnt = 0; state IDLE.
- start→busy: 1 cycle. Minimum per-compare cost: FILL + CMP = 2 cycles.
- Match latency: m_valid rises the cycle after CMP.
- start while busy: ignored. Back-to-back buckets: start accepted in the cycle after done.
- rst mid-operation: next cycle is the reset state. Any in-flight result is dropped. Readies drop the same edge.
- match_cnt wraps at 2^CNT_W. Zero-length pass is not legal: every pass carries ≥1 beat per stream.

## Structure
- Package kmer_isect_pkg: state enumeration (IDLE, PREP, FILL, CMP, EMIT, DRAIN, STEP_END, DONE), mode constants MODE_ISECT=0 and MODE_AMINUSB=1.
- Sub-module stream_head_reg (params DW): one-entry head register with hv, last, pop, and an exhausted flag. Instanced for A (DW=KEY_W) and B (DW=KEY_W+ID_W).

## Test plan
- Mode 0, NUM_STEPS=1, A={1,3,5,7}, B={3,4,7} with ids {30,40,70} → results (3,30),(7,70); match_cnt=2; one step_adv; done.
- Mode 1, same streams → results (1,0),(5,0); A tail drained correctly.
- NUM_STEPS=3, B ends first in pass 0 (A={2,9,10}, B={2}) → remaining A beats drained; step_adv×3; step_idx 0→1→2; done after third pass.
- m_ready held low 5 cycles on a match → m_valid, m_key, m_id stable; no further a/b accepts until handshake.
- Duplicates: A={4,4}, B={4,4,4} → exactly two results of key 4.
- rst asserted in EMIT → next cycle all outputs at reset values; a new start runs cleanly.

Source files
------------

// File: rtl/kmer_isect_pkg.sv
// Shared types and constants for the sorted-stream intersection engine.
package kmer_isect_pkg;

    // Engine control states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREP     = 3'd1,
        FILL     = 3'd2,
        CMP      = 3'd3,
        EMIT     = 3'd4,
        DRAIN    = 3'd5,
        STEP_END = 3'd6,
        DONE     = 3'd7
    } state_e;

    // Merge modes: emit A∩B matches, or emit keys present only in A.
    localparam logic MODE_ISECT   = 1'b0;
    localparam logic MODE_AMINUSB = 1'b1;

endpackage

// File: rtl/kmer_isect_engine_head.sv
// One-entry head register for a sorted input stream. Holds the current beat,
// its valid flag and its last marker; popping a last beat marks the stream
// exhausted for the rest of the pass.
module stream_head_reg #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          din_last,
    input  logic          pop,
    output logic          hv,
    output logic [DW-1:0] dout,
    output logic          ex
);

    logic          hv_r;
    logic [DW-1:0] data_r;
    logic          last_r;
    logic          ex_r;

    // Head storage: load on accepted beat, clear on pop, flag exhaustion on last pop.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hv_r   <= 1'b0;
            data_r <= '0;
            last_r <= 1'b0;
            ex_r   <= 1'b0;
        end else if (pop) begin
            hv_r <= 1'b0;
            if (last_r) begin
                ex_r <= 1'b1;
            end
        end else if (load) begin
            hv_r   <= 1'b1;
            data_r <= din;
            last_r <= din_last;
        end
    end

    assign hv   = hv_r;
    assign dout = data_r;
    assign ex   = ex_r;

endmodule

// File: rtl/kmer_isect_engine.sv
// Sorted-stream merge engine: compares a sorted key stream A against a sorted
// key/ID stream B over NUM_STEPS passes, emitting A∩B matches (mode 0) or
// A-only keys (mode 1), with per-pass advance and completion strobes.
module kmer_isect_engine
    import kmer_isect_pkg::*;
#(
    parameter int  KEY_W     = 64,
    parameter int  ID_W      = 32,
    parameter int  NUM_STEPS = 3,
    parameter int  CNT_W     = 32,
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [KEY_W-1:0]  a_key,
    input  logic              a_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [KEY_W-1:0]  b_key,
    input  logic [ID_W-1:0]   b_id,
    input  logic              b_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [KEY_W-1:0]  m_key,
    output logic [ID_W-1:0]   m_id,
    output logic [STEP_W-1:0] step_idx,
    output logic              step_adv,
    output logic [CNT_W-1:0]  match_cnt
);

    state_e              state_r;
    logic                mode_r;
    logic                busy_r;
    logic                done_r;
    logic                step_adv_r;
    logic                m_valid_r;
    logic [KEY_W-1:0]    m_key_r;
    logic [ID_W-1:0]     m_id_r;
    logic                em_pop_b_r;
    logic [STEP_W-1:0]   step_idx_r;
    logic [CNT_W-1:0]    match_cnt_r;

    state_e              state_n_s;
    logic                a_ready_s;
    logic                b_ready_s;
    logic                pop_a_s;
    logic                pop_b_s;
    logic                clr_s;
    logic                a_hv_n_s;
    logic                b_hv_n_s;
    logic [KEY_W-1:0]    em_key_s;
    logic [ID_W-1:0]     em_id_s;
    logic                em_pop_b_s;
    logic                last_step_s;

    logic                a_hv_s;
    logic [KEY_W-1:0]    a_head_key_s;
    logic                ex_a_s;
    logic                b_hv_s;
    logic [KEY_W+ID_W-1:0] b_head_s;
    logic [KEY_W-1:0]    b_head_key_s;
    logic [ID_W-1:0]     b_head_id_s;
    logic                ex_b_s;
    logic [KEY_W-1:0]    a_cur_key_s;

    stream_head_reg #(.DW(KEY_W)) u_head_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .load     (a_valid & a_ready_s),
        .din      (a_key),
        .din_last (a_last),
        .pop      (pop_a_s),
        .hv       (a_hv_s),
        .dout     (a_head_key_s),
        .ex       (ex_a_s)
    );

    stream_head_reg #(.DW(KEY_W + ID_W)) u_head_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .load     (b_valid & b_ready_s),
        .din      ({b_key, b_id}),
        .din_last (b_last),
        .pop      (pop_b_s),
        .hv       (b_hv_s),
        .dout     (b_head_s),
        .ex       (ex_b_s)
    );

    assign b_head_key_s = b_head_s[KEY_W+ID_W-1:ID_W];
    assign b_head_id_s  = b_head_s[ID_W-1:0];
    // A beat accepted in this FILL cycle is not in the head yet; forward it.
    assign a_cur_key_s  = a_hv_s ? a_head_key_s : a_key;
    assign last_step_s  = (step_idx_r == STEP_W'(NUM_STEPS - 1));

    // Next-state, handshake readies, head pops and the result to capture on entering EMIT.
    always_comb begin
        state_n_s  = state_r;
        a_ready_s  = 1'b0;
        b_ready_s  = 1'b0;
        pop_a_s    = 1'b0;
        pop_b_s    = 1'b0;
        clr_s      = 1'b0;
        a_hv_n_s   = a_hv_s;
        b_hv_n_s   = b_hv_s;
        em_key_s   = a_head_key_s;
        em_id_s    = '0;
        em_pop_b_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n_s = PREP;
                end else begin
                    state_n_s = IDLE;
                end
            end
            PREP: begin
                clr_s     = 1'b1;
                state_n_s = FILL;
            end
            FILL: begin
                a_ready_s = !a_hv_s && !ex_a_s;
                b_ready_s = !b_hv_s && !ex_b_s;
                // Count a beat accepted this cycle so FILL+CMP costs two cycles.
                a_hv_n_s  = a_hv_s || (a_valid && a_ready_s);
                b_hv_n_s  = b_hv_s || (b_valid && b_ready_s);
                if ((mode_r == MODE_ISECT && (ex_a_s || ex_b_s)) ||
                    (mode_r == MODE_AMINUSB && ex_a_s)) begin
                    state_n_s = DRAIN;
                end else if (mode_r == MODE_AMINUSB && ex_b_s && a_hv_n_s) begin
                    state_n_s = EMIT;
                    em_key_s  = a_cur_key_s;
                end else if (a_hv_n_s && b_hv_n_s) begin
                    state_n_s = CMP;
                end else begin
                    state_n_s = FILL;
                end
            end
            CMP: begin
                if (a_head_key_s == b_head_key_s) begin
                    if (mode_r == MODE_ISECT) begin
                        state_n_s  = EMIT;
                        em_id_s    = b_head_id_s;
                        em_pop_b_s = 1'b1;
                    end else begin
                        pop_a_s   = 1'b1;
                        pop_b_s   = 1'b1;
                        state_n_s = FILL;
                    end
                end else if (a_head_key_s < b_head_key_s) begin
                    if (mode_r == MODE_ISECT) begin
                        pop_a_s   = 1'b1;
                        state_n_s = FILL;
                    end else begin
                        state_n_s = EMIT;
                    end
                end else begin
                    pop_b_s   = 1'b1;
                    state_n_s = FILL;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    pop_a_s   = 1'b1;
                    pop_b_s   = em_pop_b_r;
                    state_n_s = FILL;
                end else begin
                    state_n_s = EMIT;
                end
            end
            DRAIN: begin
                // Discard whatever is still in the heads until both last beats are gone.
                a_ready_s = !a_hv_s && !ex_a_s;
                b_ready_s = !b_hv_s && !ex_b_s;
                pop_a_s   = a_hv_s;
                pop_b_s   = b_hv_s;
                if (ex_a_s && ex_b_s) begin
                    state_n_s = STEP_END;
                end else begin
                    state_n_s = DRAIN;
                end
            end
            STEP_END: begin
                if (last_step_s) begin
                    state_n_s = DONE;
                end else begin
                    clr_s     = 1'b1;
                    state_n_s = FILL;
                end
            end
            DONE: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Control state, registered strobes, result register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mode_r      <= MODE_ISECT;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            step_adv_r  <= 1'b0;
            m_valid_r   <= 1'b0;
            m_key_r     <= '0;
            m_id_r      <= '0;
            em_pop_b_r  <= 1'b0;
            step_idx_r  <= '0;
            match_cnt_r <= '0;
        end else begin
            state_r    <= state_n_s;
            busy_r     <= (state_n_s != IDLE);
            done_r     <= (state_n_s == DONE);
            step_adv_r <= (state_n_s == STEP_END);
            if (state_r == IDLE && start) begin
                mode_r <= mode;
            end
            if (state_r == PREP) begin
                step_idx_r  <= '0;
                match_cnt_r <= '0;
            end
            if (state_r == STEP_END && !last_step_s) begin
                step_idx_r <= step_idx_r + STEP_W'(1);
            end
            if (state_n_s == EMIT && state_r != EMIT) begin
                m_valid_r  <= 1'b1;
                m_key_r    <= em_key_s;
                m_id_r     <= em_id_s;
                em_pop_b_r <= em_pop_b_s;
            end else if (state_r == EMIT && m_ready) begin
                m_valid_r   <= 1'b0;
                match_cnt_r <= match_cnt_r + CNT_W'(1);
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign step_adv  = step_adv_r;
    assign a_ready   = a_ready_s;
    assign b_ready   = b_ready_s;
    assign m_valid   = m_valid_r;
    assign m_key     = m_key_r;
    assign m_id      = m_id_r;
    assign step_idx  = step_idx_r;
    assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_kmer_isect_engine.sv
// Bench for kmer_isect_engine: directed and random buckets over three passes,
// results compared against a two-pointer merge model of the sorted streams.
module tb_kmer_isect_engine;

    localparam int KW = 64;
    localparam int IW = 32;
    localparam int NS = 3;
    localparam int CW = 32;
    localparam int SW = 2;
    localparam int MAXB = 16;

    logic          clk = 1'b0;
    logic          rst, start, mode, busy, done;
    logic          a_valid, a_ready, a_last;
    logic [KW-1:0] a_key;
    logic          b_valid, b_ready, b_last;
    logic [KW-1:0] b_key;
    logic [IW-1:0] b_id;
    logic          m_valid, m_ready;
    logic [KW-1:0] m_key;
    logic [IW-1:0] m_id;
    logic [SW-1:0] step_idx;
    logic          step_adv;
    logic [CW-1:0] match_cnt;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int n_adv;

    logic [KW-1:0] a_arr [NS][MAXB];
    logic [KW-1:0] b_arr [NS][MAXB];
    logic [IW-1:0] id_arr[NS][MAXB];
    int            a_len [NS];
    int            b_len [NS];
    logic [KW-1:0] exp_key[$];
    logic [IW-1:0] exp_id[$];
    logic [KW-1:0] got_key[$];
    logic [IW-1:0] got_id[$];

    kmer_isect_engine #(.KEY_W(KW), .ID_W(IW), .NUM_STEPS(NS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
        .a_valid(a_valid), .a_ready(a_ready), .a_key(a_key), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_key(b_key), .b_id(b_id), .b_last(b_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_key(m_key), .m_id(m_id),
        .step_idx(step_idx), .step_adv(step_adv), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: per pass, walk both sorted lists with two pointers.
    function automatic void build_expected(input bit md);
        exp_key.delete();
        exp_id.delete();
        for (int p = 0; p < NS; p++) begin
            int i = 0;
            int j = 0;
            while (i < a_len[p] && j < b_len[p]) begin
                if (a_arr[p][i] == b_arr[p][j]) begin
                    if (!md) begin exp_key.push_back(a_arr[p][i]); exp_id.push_back(id_arr[p][j]); end
                    i++; j++;
                end else if (a_arr[p][i] < b_arr[p][j]) begin
                    if (md) begin exp_key.push_back(a_arr[p][i]); exp_id.push_back('0); end
                    i++;
                end else begin
                    j++;
                end
            end
            if (md) begin
                while (i < a_len[p]) begin
                    exp_key.push_back(a_arr[p][i]); exp_id.push_back('0); i++;
                end
            end
        end
    endfunction

    task automatic set_pass(input int p, input int na, input int va[4], input int nb, input int vb[4], input int ib[4]);
        a_len[p] = na;
        b_len[p] = nb;
        for (int i = 0; i < na; i++) a_arr[p][i] = 64'(va[i]);
        for (int i = 0; i < nb; i++) begin b_arr[p][i] = 64'(vb[i]); id_arr[p][i] = 32'(ib[i]); end
    endtask

    task automatic gen_random();
        for (int p = 0; p < NS; p++) begin
            logic [KW-1:0] k;
            a_len[p] = int'($urandom_range(1, 10));
            b_len[p] = int'($urandom_range(1, 10));
            k = 64'($urandom_range(0, 3));
            for (int i = 0; i < a_len[p]; i++) begin a_arr[p][i] = k; k = k + 64'($urandom_range(0, 3)); end
            k = 64'($urandom_range(0, 3));
            for (int i = 0; i < b_len[p]; i++) begin
                b_arr[p][i] = k; id_arr[p][i] = $urandom; k = k + 64'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic drive_a(input int deadline);
        for (int p = 0; p < NS; p++) begin
            for (int i = 0; i < a_len[p]; i++) begin
                bit acc = 1'b0;
                while (!acc && cyc < deadline) begin
                    @(negedge clk);
                    a_valid = ($urandom_range(0, 3) != 0);
                    a_key   = a_arr[p][i];
                    a_last  = (i == a_len[p] - 1);
                    #1;
                    if (a_valid && a_ready) acc = 1'b1;
                end
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic drive_b(input int deadline);
        for (int p = 0; p < NS; p++) begin
            for (int i = 0; i < b_len[p]; i++) begin
                bit acc = 1'b0;
                while (!acc && cyc < deadline) begin
                    @(negedge clk);
                    b_valid = ($urandom_range(0, 3) != 0);
                    b_key   = b_arr[p][i];
                    b_id    = id_arr[p][i];
                    b_last  = (i == b_len[p] - 1);
                    #1;
                    if (b_valid && b_ready) acc = 1'b1;
                end
            end
        end
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic collect(input int deadline, input bit stall_first);
        bit            seen_done = 1'b0;
        bit            hold = 1'b0;
        int            stall_ctr = 0;
        int            iter = 0;
        logic [KW-1:0] hk;
        logic [IW-1:0] hi;
        n_adv = 0;
        while (!seen_done && cyc < deadline) begin
            @(negedge clk);
            iter++;
            // A start while busy must be ignored.
            if (iter == 4) begin start = 1'b1; mode = ~mode; end
            if (iter == 5) begin start = 1'b0; mode = ~mode; end
            m_ready = (stall_first && stall_ctr < 5) ? 1'b0 : ($urandom_range(0, 2) != 0);
            #1;
            if (hold) begin
                check("m_valid_hold", 64'(m_valid), 64'd1);
                check("m_key_hold", m_key, hk);
                check("m_id_hold", 64'(m_id), 64'(hi));
                check("no_accept_in_emit", 64'({a_ready, b_ready}), 64'd0);
            end
            if (m_valid && !m_ready) begin
                hold = 1'b1; hk = m_key; hi = m_id;
                if (stall_first) stall_ctr++;
            end else begin
                hold = 1'b0;
            end
            if (m_valid && m_ready) begin got_key.push_back(m_key); got_id.push_back(m_id); end
            if (step_adv) begin
                check("step_idx_at_adv", 64'(step_idx), 64'(n_adv));
                n_adv++;
            end
            if (done) seen_done = 1'b1;
        end
        if (!seen_done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_bucket(input bit md, input bit stall_first);
        int deadline;
        build_expected(md);
        got_key.delete();
        got_id.delete();
        deadline = cyc + 3000;
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        fork
            drive_a(deadline);
            drive_b(deadline);
            collect(deadline, stall_first);
        join
        check("result_count", 64'(got_key.size()), 64'(exp_key.size()));
        for (int i = 0; i < exp_key.size() && i < got_key.size(); i++) begin
            check("result_key", got_key[i], exp_key[i]);
            check("result_id", 64'(got_id[i]), 64'(exp_id[i]));
        end
        check("match_cnt", 64'(match_cnt), 64'(exp_key.size()));
        check("step_adv_count", 64'(n_adv), 64'(NS));
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);
        m_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},      64'(busy), 64'd0);
        check({tag, "_done"},      64'(done), 64'd0);
        check({tag, "_a_ready"},   64'(a_ready), 64'd0);
        check({tag, "_b_ready"},   64'(b_ready), 64'd0);
        check({tag, "_m_valid"},   64'(m_valid), 64'd0);
        check({tag, "_m_key"},     m_key, 64'd0);
        check({tag, "_m_id"},      64'(m_id), 64'd0);
        check({tag, "_step_idx"},  64'(step_idx), 64'd0);
        check({tag, "_step_adv"},  64'(step_adv), 64'd0);
        check({tag, "_match_cnt"}, 64'(match_cnt), 64'd0);
    endtask

    initial begin
        bit got_mv;
        rst = 1'b1; start = 1'b0; mode = 1'b0; m_ready = 1'b0;
        a_valid = 1'b0; a_key = '0; a_last = 1'b0;
        b_valid = 1'b0; b_key = '0; b_id = '0; b_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Basic intersect / A-minus-B on A={1,3,5,7}, B={3,4,7}.
        for (int p = 0; p < NS; p++) set_pass(p, 4, '{1, 3, 5, 7}, 3, '{3, 4, 7, 0}, '{30, 40, 70, 0});
        run_bucket(1'b0, 1'b0);
        run_bucket(1'b1, 1'b0);
        // Held-off result: m_ready low for 5 cycles on a match.
        run_bucket(1'b0, 1'b1);

        // B ends first; A tail drained.
        for (int p = 0; p < NS; p++) set_pass(p, 3, '{2, 9, 10, 0}, 1, '{2, 0, 0, 0}, '{22, 0, 0, 0});
        run_bucket(1'b0, 1'b0);
        run_bucket(1'b1, 1'b0);

        // Duplicate keys pair off one-to-one.
        for (int p = 0; p < NS; p++) set_pass(p, 2, '{4, 4, 0, 0}, 3, '{4, 4, 4, 0}, '{41, 42, 43, 0});
        run_bucket(1'b0, 1'b0);

        // Reset while a result waits in EMIT.
        @(negedge clk);
        a_valid = 1'b1; a_key = 64'd5; a_last = 1'b1;
        b_valid = 1'b1; b_key = 64'd5; b_id = 32'd9; b_last = 1'b1;
        start = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        got_mv = 1'b0;
        for (int i = 0; i < 20 && !got_mv; i++) begin
            @(negedge clk);
            if (m_valid) got_mv = 1'b1;
        end
        check("emit_before_rst_valid", 64'(m_valid), 64'd1);
        check("emit_before_rst_key", m_key, 64'd5);
        check("emit_before_rst_id", 64'(m_id), 64'd9);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst");
        rst = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;

        // Random buckets in both modes.
        for (int t = 0; t < 24; t++) begin
            gen_random();
            run_bucket(t[0], (t % 5) == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
